// File: rtl/j202_wb_pkg.sv
// Shared Wishbone widths, master FSM state encoding and command payload.
package j202_wb_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } cmd_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles and flags the last allowed one.
module wb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    // One extra count of headroom so the increment on the expiring edge cannot wrap.
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire_c = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding command-to-Wishbone-classic master with ack/err/timeout response.
module wb_cmd_master
    import j202_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_tmo_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic [DAT_W-1:0] wbm_dat_i,
    output logic             busy_o
);

    state_e state;
    cmd_t   cmd_q;
    logic   bus_q;
    logic   accept;
    logic   tmo_en;
    logic   expire_c;

    assign cmd_ready_o = (state == ST_IDLE) && !wb_rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;

    // cyc and stb share one register so they can never disagree.
    assign wbm_cyc_o = bus_q;
    assign wbm_stb_o = bus_q;
    assign wbm_we_o  = cmd_q.we;
    assign wbm_sel_o = cmd_q.sel;
    assign wbm_adr_o = cmd_q.adr;
    assign wbm_dat_o = cmd_q.dat;

    assign tmo_en = (state == ST_BUS) && bus_q && !wbm_ack_i && !wbm_err_i;

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr      (accept),
        .en       (tmo_en),
        .expire_c (expire_c)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            bus_q       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_q  <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
                        state  <= ST_BUS;
                        busy_o <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // First BUS cycle only raises cyc/stb; slave inputs are sampled afterwards.
                    if (!bus_q) begin
                        bus_q <= 1'b1;
                    end else if (wbm_err_i) begin
                        bus_q       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_tmo_o   <= 1'b0;
                        state       <= ST_RESP;
                    end else if (wbm_ack_i) begin
                        bus_q       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= cmd_q.we ? '0 : wbm_dat_i;
                        rsp_err_o   <= 1'b0;
                        rsp_tmo_o   <= 1'b0;
                        state       <= ST_RESP;
                    end else if (expire_c) begin
                        bus_q       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_tmo_o   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    bus_q       <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master against a small Wishbone slave model.
module tb_wb_cmd_master;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, sdat;
    logic        ack, err;
    logic        busy;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .rsp_tmo_o   (rsp_tmo),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_ack_i   (ack),
        .wbm_err_i   (err),
        .wbm_dat_i   (sdat),
        .busy_o      (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Slave: 0 = zero-wait ack, 1 = silent, 2 = ack+err together, 3 = one wait state
    int          slv_mode = 0;
    logic        ws_q = 1'b0;
    logic [31:0] mem [4];

    always_comb begin
        ack = 1'b0;
        err = 1'b0;
        if (slv_mode == 0) begin
            ack = cyc & stb;
        end else if (slv_mode == 2) begin
            ack = cyc & stb;
            err = cyc & stb;
        end else if (slv_mode == 3) begin
            ack = cyc & stb & ws_q;
        end
    end

    assign sdat = mem[adr[3:2]];

    always @(posedge clk) begin
        ws_q <= cyc & stb & ~ack;
        if (cyc && stb && ack && !err && we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) mem[adr[3:2]][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t        sbq[$];
    int          stb_hi = 0;
    int          stb_pulses = 0;
    int          stb_rise = 0;
    int          rsp_rise = 0;
    logic        stb_prev = 1'b0;
    logic        rv_prev = 1'b0;
    logic [31:0] snap_adr = '0;
    logic [31:0] snap_dat = '0;
    logic [3:0]  snap_sel = '0;
    logic        snap_we = 1'b0;

    // Bus/response monitor; responses are popped when the handshake is about to occur.
    always @(negedge clk) begin
        exp_t e;
        chk("stb_without_cyc", 32'(stb & ~cyc), 32'd0);
        if (stb) stb_hi++;
        if (stb && !stb_prev) begin
            stb_rise   = cyc_cnt;
            stb_pulses++;
            snap_adr   = adr;
            snap_dat   = wdat;
            snap_sel   = sel;
            snap_we    = we;
        end
        stb_prev = stb;
        if (rsp_valid && !rv_prev) rsp_rise = cyc_cnt;
        rv_prev = rsp_valid;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_dat", rsp_dat, e.dat);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_tmo", 32'(rsp_tmo), 32'(e.tmo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic push, input logic [31:0] edat,
                        input logic eerr, input logic etmo, output int hs);
        int budget;
        if (push) sbq.push_back('{dat: edat, err: eerr, tmo: etmo});
        cmd_we = w;
        cmd_adr = a;
        cmd_dat = d;
        cmd_sel = s;
        cmd_valid = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 100) begin
            tick();
            budget++;
        end
        if (!cmd_ready) chk("cmd_accept_wait", 32'(cmd_ready), 32'd1);
        stb_hi = 0;
        stb_pulses = 0;
        tick();
        hs = cyc_cnt;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        tick();
    endtask

    initial begin
        int hs, hs2, budget;
        mem[0] = 32'h0;
        mem[1] = 32'hA5A5_1234;
        mem[2] = 32'h0;
        mem[3] = 32'h0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_adr", adr, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write
        send(1'b1, 32'h3000_0000, 32'h0000_0001, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0, hs);
        wait_sb();
        chk("wr_mem", mem[0], 32'h0000_0001);
        chk("wr_pulses", 32'(stb_pulses), 32'd1);
        chk("wr_stb_cycles", 32'(stb_hi), 32'd1);
        chk("wr_stb_lat", 32'(stb_rise - hs), 32'd1);
        chk("wr_rsp_lat", 32'(rsp_rise - hs), 32'd2);
        chk("wr_bus_adr", snap_adr, 32'h3000_0000);
        chk("wr_bus_dat", snap_dat, 32'h0000_0001);
        chk("wr_bus_sel", 32'(snap_sel), 32'hF);
        chk("wr_bus_we", 32'(snap_we), 32'd1);

        // Back-to-back reads; second command accepted four edges after the first
        send(1'b0, 32'h3000_0000, 32'd0, 4'hF, 1'b1, 32'h0000_0001, 1'b0, 1'b0, hs);
        send(1'b0, 32'h3000_0004, 32'd0, 4'hF, 1'b1, 32'hA5A5_1234, 1'b0, 1'b0, hs2);
        chk("rd_rsp_lat", 32'(rsp_rise - hs), 32'd2);
        chk("b2b_accept_gap", 32'(hs2 - hs), 32'd4);
        wait_sb();
        chk("rd2_rsp_lat", 32'(rsp_rise - hs2), 32'd2);
        chk("rd2_bus_we", 32'(snap_we), 32'd0);

        // Partial byte-lane write then read back
        send(1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'b0101, 1'b1, 32'd0, 1'b0, 1'b0, hs);
        send(1'b0, 32'h3000_0008, 32'd0, 4'hF, 1'b1, 32'h00AD_00EF, 1'b0, 1'b0, hs);
        wait_sb();
        chk("sel_mem", mem[2], 32'h00AD_00EF);

        // Silent slave: timeout after TMO stb cycles
        slv_mode = 1;
        send(1'b1, 32'h3000_000C, 32'd5, 4'hF, 1'b1, 32'd0, 1'b1, 1'b1, hs);
        wait_sb();
        chk("tmo_stb_cycles", 32'(stb_hi), 32'(TMO));
        chk("tmo_pulses", 32'(stb_pulses), 32'd1);
        chk("tmo_rsp_lat", 32'(rsp_rise - hs), 32'(TMO + 1));
        chk("tmo_mem", mem[3], 32'd0);

        // ack and err on the same edge: err wins, no data
        slv_mode = 2;
        send(1'b0, 32'h3000_0004, 32'd0, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0, hs);
        wait_sb();

        // One wait state read
        slv_mode = 3;
        send(1'b0, 32'h3000_0004, 32'd0, 4'hF, 1'b1, 32'hA5A5_1234, 1'b0, 1'b0, hs);
        wait_sb();
        chk("ws_stb_cycles", 32'(stb_hi), 32'd2);
        chk("ws_rsp_lat", 32'(rsp_rise - hs), 32'd3);

        // Response backpressure with a new command pending
        slv_mode = 0;
        rsp_ready = 1'b0;
        send(1'b0, 32'h3000_0000, 32'd0, 4'hF, 1'b1, 32'h0000_0001, 1'b0, 1'b0, hs);
        sbq.push_back('{dat: 32'd0, err: 1'b0, tmo: 1'b0});
        cmd_we = 1'b1;
        cmd_adr = 32'h3000_0004;
        cmd_dat = 32'h1111_2222;
        cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        budget = 0;
        while (!rsp_valid && budget < 50) begin
            tick();
            budget++;
        end
        chk("bp_rsp_arrives", 32'(rsp_valid), 32'd1);
        stb_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_dat", rsp_dat, 32'h0000_0001);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_stb", 32'(stb), 32'd0);
            tick();
        end
        chk("bp_no_new_stb", 32'(stb_pulses), 32'd0);
        rsp_ready = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            tick();
            budget++;
        end
        chk("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        wait_sb();
        chk("bp_mem", mem[1], 32'h1111_2222);

        // Reset pulse in the middle of a bus cycle abandons it
        slv_mode = 1;
        send(1'b1, 32'h3000_000C, 32'd7, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0, hs);
        tick(); tick();
        chk("mid_cyc_before", 32'(cyc), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_cyc_after", 32'(cyc), 32'd0);
        chk("mid_stb_after", 32'(stb), 32'd0);
        chk("mid_busy_after", 32'(busy), 32'd0);
        chk("mid_cmd_ready_rst", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("mid_mem", mem[3], 32'd0);

        slv_mode = 0;
        send(1'b1, 32'h3000_000C, 32'h0000_0077, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0, hs);
        send(1'b0, 32'h3000_000C, 32'd0, 4'hF, 1'b1, 32'h0000_0077, 1'b0, 1'b0, hs);
        wait_sb();
        chk("post_rst_rsp_lat", 32'(rsp_rise - hs), 32'd2);

        chk("sb_final", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
